// File: rtl/core_out_monitor.sv
// Core output bus monitor: logs every bus change with a cycle stamp into a
// show-ahead FIFO and ends the run on bus stability or timeout.
module core_out_monitor #(
  parameter int OUT_WIDTH      = 8,
  parameter int FIFO_DEPTH     = 16,
  parameter int CNT_W          = 16,
  parameter int STABLE_CYCLES  = 20,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OUT_WIDTH-1:0] mon_in,
  input  logic [OUT_WIDTH-1:0] expected,
  input  logic                 rd_en,
  output logic [OUT_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]     rd_stamp,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 overflow,
  output logic [CNT_W-1:0]     change_count,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      OCC_FULL   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIME_END   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DONE} state_t;

  state_t                 state, state_nx;
  logic [OUT_WIDTH-1:0]   last_val;
  logic [CNT_W-1:0]       cycle;
  logic [CNT_W-1:0]       stable_cnt;
  logic [OUT_WIDTH-1:0]   mem_data  [FIFO_DEPTH];
  logic [CNT_W-1:0]       mem_stamp [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            occ;

  logic changed, push_req, push, pop, drop, stable_hit, timeout_hit;

  always_comb begin
    changed     = (state == ST_RUN) && (mon_in != last_val);
    push_req    = changed;
    pop         = rd_en && (occ != '0);
    push        = push_req && ((occ != OCC_FULL) || pop);
    drop        = push_req && (occ == OCC_FULL) && !pop;
    // Stability counts only once the bus has moved at least once.
    stable_hit  = (state == ST_RUN) && !changed && (change_count != '0) &&
                  (stable_cnt == STABLE_END);
    timeout_hit = (state == ST_RUN) && (cycle == TIME_END);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INIT: state_nx = ST_RUN;
      ST_RUN: begin
        if (stable_hit || timeout_hit) state_nx = ST_DONE;
        else                           state_nx = ST_RUN;
      end
      ST_DONE: state_nx = ST_DONE;
      default: state_nx = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_val     <= '0;
      cycle        <= '0;
      stable_cnt   <= '0;
      change_count <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          last_val <= mon_in;
          cycle    <= '0;
        end
        ST_RUN: begin
          if (cycle != CNT_MAX) cycle <= cycle + 1'b1;
          if (changed) begin
            last_val   <= mon_in;
            stable_cnt <= '0;
            if (change_count != CNT_MAX) change_count <= change_count + 1'b1;
          end else if (change_count != '0) begin
            stable_cnt <= stable_cnt + 1'b1;
          end
          // Stable completion takes priority over a coincident timeout.
          if (stable_hit) begin
            done    <= 1'b1;
            pass    <= (last_val == expected);
            timeout <= 1'b0;
          end else if (timeout_hit) begin
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: ;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: contents are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr]  <= mon_in;
      mem_stamp[wr_ptr] <= cycle;
    end
  end

  always_comb begin
    fifo_empty = (occ == '0);
    fifo_full  = (occ == OCC_FULL);
    rd_data    = fifo_empty ? '0 : mem_data[rd_ptr];
    rd_stamp   = fifo_empty ? '0 : mem_stamp[rd_ptr];
  end

endmodule

// File: tb/tb_core_out_monitor.sv
// Scoreboard bench for core_out_monitor: a cycle model predicts FIFO entries
// and status flags; pops are checked against the predicted queue head.
module tb_core_out_monitor;

  localparam int DEPTH   = 4;
  localparam int STABLE  = 20;
  localparam int TIMEOUT = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mon_in = 8'h00;
  logic [7:0]  expected = 8'h00;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_data;
  logic [15:0] rd_stamp;
  logic        fifo_empty, fifo_full, overflow, done, pass, timeout;
  logic [15:0] change_count;

  core_out_monitor #(
    .OUT_WIDTH(8), .FIFO_DEPTH(DEPTH), .CNT_W(16),
    .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .mon_in(mon_in), .expected(expected),
    .rd_en(rd_en), .rd_data(rd_data), .rd_stamp(rd_stamp),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overflow(overflow),
    .change_count(change_count), .done(done), .pass(pass), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] stamp;
    logic [7:0]  data;
  } ent_t;

  ent_t        sb[$];
  int          m_state;
  logic [7:0]  m_last;
  logic [15:0] m_cycle, m_stable, m_cc;
  logic        m_done, m_pass, m_timeout, m_ovf;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_state = 0; m_last = 8'h00; m_cycle = 16'd0; m_stable = 16'd0; m_cc = 16'd0;
    m_done = 1'b0; m_pass = 1'b0; m_timeout = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("pass", {31'd0, pass}, {31'd0, m_pass});
    check_eq("timeout", {31'd0, timeout}, {31'd0, m_timeout});
    check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    check_eq("change_count", {16'd0, change_count}, {16'd0, m_cc});
    check_eq("fifo_empty", {31'd0, fifo_empty}, {31'd0, sb.size() == 0});
    check_eq("fifo_full", {31'd0, fifo_full}, {31'd0, sb.size() == DEPTH});
    if (sb.size() != 0) begin
      check_eq("head_data", {24'd0, rd_data}, {24'd0, sb[0].data});
      check_eq("head_stamp", {16'd0, rd_stamp}, {16'd0, sb[0].stamp});
    end else begin
      check_eq("empty_data", {24'd0, rd_data}, 32'd0);
      check_eq("empty_stamp", {16'd0, rd_stamp}, 32'd0);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic [7:0] v, input logic rd);
    logic hit;
    ent_t e;
    mon_in = v;
    rd_en  = rd;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    if (rd && sb.size() != 0) sb.delete(0);
    if (m_state == 0) begin
      m_last  = v;
      m_cycle = 16'd0;
      m_state = 1;
    end else if (m_state == 1) begin
      hit = 1'b0;
      if (v != m_last) begin
        m_last   = v;
        m_stable = 16'd0;
        if (m_cc != 16'hFFFF) m_cc++;
        if (sb.size() < DEPTH) begin
          e.stamp = m_cycle;
          e.data  = v;
          sb.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_cc != 16'd0) begin
        if (m_stable == 16'(STABLE - 1)) hit = 1'b1;
        m_stable++;
      end
      if (hit) begin
        m_done = 1'b1; m_pass = (m_last == expected); m_timeout = 1'b0; m_state = 2;
      end else if (m_cycle == 16'(TIMEOUT - 1)) begin
        m_done = 1'b1; m_pass = 1'b0; m_timeout = 1'b1; m_state = 2;
      end
      if (m_cycle != 16'hFFFF) m_cycle++;
    end
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    compare_all();
    reset = 1'b0;
  endtask

  task automatic pop_expect(input logic [15:0] st, input logic [7:0] d);
    check_eq("pop_stamp", {16'd0, rd_stamp}, {16'd0, st});
    check_eq("pop_data", {24'd0, rd_data}, {24'd0, d});
    step(mon_in, 1'b1);
  endtask

  function automatic logic [7:0] seq_b(input int k);
    if (k < 3)  return 8'h00;
    if (k < 7)  return 8'h05;
    if (k < 12) return 8'h0A;
    return 8'h2D;
  endfunction

  int done_k;

  initial begin
    model_clear();

    // Timeout with a bus that never moves.
    expected = 8'h00;
    do_reset();
    step(8'h00, 1'b0);
    done_k = -1;
    for (int k = 0; k < 1003; k++) begin
      step(8'h00, 1'b0);
      if (done && done_k < 0) done_k = k;
    end
    check_eq("a_done_k", done_k, 32'd999);
    check_eq("a_timeout", {31'd0, timeout}, 32'd1);
    check_eq("a_pass", {31'd0, pass}, 32'd0);
    check_eq("a_cc", {16'd0, change_count}, 32'd0);
    check_eq("a_empty", {31'd0, fifo_empty}, 32'd1);

    // Three steps, matching expected value.
    for (int pass_run = 0; pass_run < 2; pass_run++) begin
      expected = (pass_run == 0) ? 8'h2D : 8'h2C;
      do_reset();
      step(8'h00, 1'b0);
      done_k = -1;
      for (int k = 0; k < 200 && !done; k++) begin
        step(seq_b(k), 1'b0);
        if (done) done_k = k;
      end
      check_eq("b_done_k", done_k, 32'd32);
      check_eq("b_pass", {31'd0, pass}, (pass_run == 0) ? 32'd1 : 32'd0);
      check_eq("b_timeout", {31'd0, timeout}, 32'd0);
      check_eq("b_cc", {16'd0, change_count}, 32'd3);
      pop_expect(16'd3, 8'h05);
      pop_expect(16'd7, 8'h0A);
      pop_expect(16'd12, 8'h2D);
      check_eq("b_empty", {31'd0, fifo_empty}, 32'd1);
      step(mon_in, 1'b1);
    end

    // Six changes into a four-entry FIFO with no reads.
    expected = 8'h06;
    do_reset();
    step(8'h00, 1'b0);
    for (int k = 0; k < 200 && !done; k++) begin
      step((k > 6) ? 8'd6 : 8'(k), 1'b0);
      if (k == 4) begin
        check_eq("d_full4", {31'd0, fifo_full}, 32'd1);
        check_eq("d_ovf4", {31'd0, overflow}, 32'd0);
      end
      if (k == 5) check_eq("d_ovf5", {31'd0, overflow}, 32'd1);
    end
    check_eq("d_done", {31'd0, done}, 32'd1);
    check_eq("d_cc", {16'd0, change_count}, 32'd6);
    for (int i = 1; i <= 4; i++) pop_expect(16'(i), 8'(i));
    check_eq("d_empty", {31'd0, fifo_empty}, 32'd1);

    // Push and pop together while full.
    expected = 8'h05;
    do_reset();
    step(8'h00, 1'b0);
    for (int k = 0; k < 200 && !done; k++) begin
      step((k > 5) ? 8'd5 : 8'(k), k == 5);
      if (k == 5) begin
        check_eq("e_ovf", {31'd0, overflow}, 32'd0);
        check_eq("e_full", {31'd0, fifo_full}, 32'd1);
        check_eq("e_head", {16'd0, rd_stamp}, 32'd2);
      end
    end
    check_eq("e_pass", {31'd0, pass}, 32'd1);
    for (int i = 2; i <= 5; i++) pop_expect(16'(i), 8'(i));

    // Asynchronous reset in the middle of a run.
    expected = 8'h09;
    do_reset();
    step(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) step((k >= 2) ? 8'd2 : ((k == 1) ? 8'd1 : 8'd0), 1'b0);
    check_eq("f_pre_cc", {16'd0, change_count}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(8'h00, 1'b0);
    for (int k = 0; k < 4; k++) step((k >= 2) ? 8'h09 : 8'h00, 1'b0);
    check_eq("f_stamp", {16'd0, rd_stamp}, 32'd2);
    check_eq("f_data", {24'd0, rd_data}, 32'h09);
    check_eq("f_cc", {16'd0, change_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_out_monitor.md
Name: core_out_monitor

Overview:
- Parametrised, synthesizable monitor for the core's output bus. It replaces ad-hoc waveform inspection of the core output.
- Detects every change on the monitored bus and logs {cycle stamp, value} into an internal FIFO.
- Declares completion when the bus stays stable for a programmable number of cycles, or when a timeout expires.
- Reports pass/fail against an expected final value. It sits beside the core in simulation and FPGA bring-up tops.

Parameters:
- OUT_WIDTH, 8, width of monitored bus and expected value
- FIFO_DEPTH, 16, log entries (power of two, >=2)
- CNT_W, 16, width of cycle stamp, timeout and change counters
- STABLE_CYCLES, 20, consecutive unchanged cycles (after >=1 change) that end the run
- TIMEOUT_CYCLES, 1000, RUN cycles after which the run is aborted

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- mon_in  in  OUT_WIDTH  core output bus being monitored
- expected  in  OUT_WIDTH  expected final bus value, sampled on entry to DONE
- rd_en  in  1  pop head FIFO entry
- rd_data  out  OUT_WIDTH  head entry value (show-ahead)
- rd_stamp  out  CNT_W  head entry cycle stamp
- fifo_empty  out  1  FIFO holds no entries
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a change was dropped because the FIFO was full
- change_count  out  CNT_W  number of changes detected (saturating)
- done  out  1  run finished (sticky until reset)
- pass  out  1  valid when done: final value == expected, no timeout
- timeout  out  1  sticky: run ended by timeout

Behaviour:
- Reset (async assert, sync release):
  - State goes to INIT.
  - FIFO pointers are zero; fifo_empty=1; fifo_full=0.
  - overflow, done, pass and timeout are 0.
  - change_count, the cycle counter and the stable counter are 0.
  - rd_data and rd_stamp are 0.
  - Reset asserted mid-run clears everything immediately, including FIFO contents (they become invisible).
- States: INIT -> RUN -> DONE. DONE exits only via reset.
- INIT:
  - Lasts exactly one clock after reset release.
  - Samples mon_in into last_val.
  - Does not log and sets cycle=0.
  - Then goes to RUN.
- RUN, every clock:
  - cycle increments, saturating at all-ones.
  - If mon_in != last_val:
    - last_val <= mon_in.
    - change_count increments (saturating).
    - stable counter resets to 0.
    - Push {cycle, mon_in}, where the stamp is the cycle value before increment.
  - If mon_in == last_val and change_count>0: stable counter increments.
  - When the stable counter reaches STABLE_CYCLES-1 while incrementing: go to DONE. done=1; pass=(last_val==expected).
  - Otherwise, if cycle reaches TIMEOUT_CYCLES-1: go to DONE. done=1; timeout=1; pass=0.
  - If both conditions occur in the same cycle, the stable completion wins: timeout=0.
- DONE:
  - No further logging or counting.
  - FIFO remains readable.
  - done, pass, timeout and change_count hold.
- FIFO:
  - Show-ahead: rd_data/rd_stamp reflect the head entry combinationally from registers. They read 0 when empty.
  - Pop occurs when rd_en && !fifo_empty. rd_en while empty is ignored, with no error.
  - Push when full without a simultaneous pop: the entry is dropped and overflow is set (sticky). The change is still counted.
  - Push and pop in the same cycle when full: both succeed and the count is unchanged.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Full/empty is determined by an occupancy counter of width log2(FIFO_DEPTH)+1.
- Latency:
  - A change on mon_in at edge N is visible in the FIFO (fifo_empty=0) after edge N+1.
  - done rises on the clock edge that completes the stable or timeout condition.

Test Plan:
- Reset then hold mon_in=0x00 → after 1000 RUN cycles: done=1, timeout=1, pass=0, change_count=0, fifo_empty=1.
- mon_in steps 0x00→0x05→0x0A→0x2D at RUN cycles 3, 7, 12, then held, with expected=0x2D:
  - done=1 exactly 20 cycles after the last change.
  - pass=1, change_count=3.
  - Three pops return (3,0x05), (7,0x0A), (12,0x2D).
- Same sequence with expected=0x2C → done=1, pass=0, timeout=0.
- FIFO_DEPTH=4, six changes, no reads:
  - fifo_full=1 after the 4th change; overflow=1 after the 5th.
  - change_count=6; pops return only the first four entries.
- FIFO full with rd_en=1 in the same cycle as a new change → overflow stays 0, fifo_full stays 1, head advances, newest entry is stored.
- Reset asserted mid-RUN after two logged changes → all outputs return to reset values immediately (asynchronously). After release, the run restarts from INIT with cycle=0.
